// File: rtl/sample_distributor_if.sv
// Shared bus between the sample dispatcher and its environment: sample handshake,
// channel enables, per-channel start/done strobes and frame status.
interface sample_distributor_if #(
    parameter int N = 25
);
    logic [N-1:0] x_in;
    logic         x_valid;
    logic         x_ready;
    logic         sw1;
    logic         sw2;
    logic         sw3;
    logic [N-1:0] xk;
    logic         start1;
    logic         start2;
    logic         start3;
    logic         done1;
    logic         done2;
    logic         done3;
    logic [2:0]   ch_mask;
    logic         busy;
    logic         frame_done;
    logic         timeout_err;

    modport master (
        output x_in, x_valid, sw1, sw2, sw3, done1, done2, done3,
        input  x_ready, xk, start1, start2, start3, ch_mask, busy, frame_done, timeout_err
    );

    modport slave (
        input  x_in, x_valid, sw1, sw2, sw3, done1, done2, done3,
        output x_ready, xk, start1, start2, start3, ch_mask, busy, frame_done, timeout_err
    );
endinterface

// File: rtl/sample_distributor.sv
// Latches one sample per frame and starts enabled channels 1..3 in order, one at a time;
// x_ready only in IDLE. DISTRIB_TIMEOUT_EN adds a 255-cycle per-channel watchdog.
module sample_distributor #(
    parameter int N = 25
) (
    input  logic               clk,
    input  logic               reset,
    sample_distributor_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   idx_q, idx_d;
    logic [N-1:0] xk_q, xk_d;
    logic [2:0]   mask_q, mask_d;
    logic [2:0]   start_q, start_d;
    logic         frame_done_q, frame_done_d;

    logic [2:0]   done_v;
    logic         done_sel;
    logic         tmo_hit;
    logic         accept;

    assign done_v   = {bus.done3, bus.done2, bus.done1};
    assign done_sel = done_v[idx_q];

    assign bus.x_ready = (state_q == IDLE) && !reset;
    assign bus.busy    = (state_q != IDLE);
    assign accept      = bus.x_valid && bus.x_ready;

`ifdef DISTRIB_TIMEOUT_EN
    logic [7:0] wdog_q, wdog_d;
    logic       tmo_err_q, tmo_err_d;

    // wdog_q counts completed WAIT cycles; the 255th silent cycle forces an advance
    assign tmo_hit = (state_q == WAIT) && !done_sel && (wdog_q == 8'd254);

    always_comb begin
        wdog_d    = (state_q == WAIT) ? wdog_q + 8'd1 : 8'd0;
        tmo_err_d = tmo_err_q | tmo_hit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_q    <= 8'd0;
            tmo_err_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign bus.timeout_err = tmo_err_q;
`else
    assign tmo_hit         = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= 2'd0;
            xk_q         <= '0;
            mask_q       <= 3'b000;
            start_q      <= 3'b000;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            xk_q         <= xk_d;
            mask_q       <= mask_d;
            start_q      <= start_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        xk_d    = xk_q;
        mask_d  = mask_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    xk_d    = bus.x_in;
                    mask_d  = {bus.sw3, bus.sw2, bus.sw1};
                    idx_d   = 2'd0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (mask_q[idx_q]) begin
                    state_d = WAIT;
                end else if (idx_q == 2'd2) begin
                    state_d = FINISH;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            WAIT: begin
                if (done_sel || tmo_hit) begin
                    if (idx_q == 2'd2) begin
                        state_d = FINISH;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ISSUE;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered strobes are decoded from the next state so they line up with it
    always_comb begin
        start_d      = 3'b000;
        frame_done_d = (state_d == FINISH);
        if (state_d == ISSUE && mask_d[idx_d]) begin
            start_d[idx_d] = 1'b1;
        end
    end

    assign bus.xk         = xk_q;
    assign bus.ch_mask    = mask_q;
    assign bus.start1     = start_q[0];
    assign bus.start2     = start_q[1];
    assign bus.start3     = start_q[2];
    assign bus.frame_done = frame_done_q;

endmodule
